disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: cycles dbg_addr is held before dbg_data is captured (legal 1-255).
REQ-002 Parameter DWELL_CYCLES, default 50000000: HOLD cycles between auto-scan steps (legal >= 2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btn_next  input  1  debounced one-cycle pulse: step index +1.
REQ-006 btn_prev  input  1  debounced one-cycle pulse: step index -1.
REQ-007 page  input  2  0=register file, 1=datapath debug, 2=CP0, 3=treated as 0.
REQ-008 auto_en  input  1  level; enables auto-scan stepping.
REQ-009 live_en  input  1  level; enables continuous data tracking in HOLD.
REQ-010 dbg_data  input  32  datapath debug/register data for dbg_addr.
REQ-011 dbg_addr  output  8  select driven to datapath: {1'b0, page_r, idx}.
REQ-012 disp_addr  output  8  committed address for the display block.
REQ-013 disp_data  output  32  committed data for the display block.
REQ-014 busy  output  1  high in SETTLE and CAPTURE.

Function
REQ-015 State machine SHALL have exactly three states: HOLD, SETTLE, CAPTURE.
REQ-016 Registers SHALL include idx[4:0], page_r[1:0], settle counter, and 32-bit dwell counter.
REQ-017 Only HOLD SHALL sample events; events arriving in SETTLE or CAPTURE SHALL be dropped, not queued.
REQ-018 Page-change event: effective page (3 mapped to 0) differs from page_r -> page_r <= effective page, idx <= 0.
REQ-019 Event priority in HOLD SHALL be: page change > btn_next/btn_prev > auto tick.
REQ-020 btn_next alone -> idx <= idx+1 mod 32 (31 wraps to 0); btn_prev alone -> idx <= idx-1 mod 32 (0 wraps to 31).
REQ-021 btn_next and btn_prev high in the same cycle SHALL cancel: no step, no state change.
REQ-022 Dwell counter SHALL increment each HOLD cycle with auto_en=1, and clear when auto_en=0, on any step, or on leaving HOLD.
REQ-023 Auto tick SHALL fire in the HOLD cycle where the dwell counter equals DWELL_CYCLES-1, stepping idx +1 with wrap.
REQ-024 Any accepted event SHALL move HOLD->SETTLE on the same edge, with dbg_addr showing the new value after that edge.
REQ-025 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to CAPTURE.
REQ-026 CAPTURE SHALL last one cycle, load disp_addr <= dbg_addr and disp_data <= dbg_data, then return to HOLD.
REQ-027 Latency: an event sampled at edge N SHALL update disp_addr/disp_data at edge N+SETTLE_CYCLES+1.
REQ-028 In HOLD with live_en=1, disp_data <= dbg_data every cycle while disp_addr stays unchanged.
REQ-029 In HOLD with live_en=0, disp_data and disp_addr SHALL hold their values.
REQ-030 dbg_addr SHALL never change outside the HOLD->SETTLE transition or reset.

Reset
REQ-031 rst=1 SHALL set idx=0, page_r=0, dwell and settle counters=0, dbg_addr=0x00, disp_addr=0x00, disp_data=0, and state=SETTLE (busy=1).
REQ-032 With rst=0 after reset, the block SHALL perform one SETTLE/CAPTURE of address 0x00 and then enter HOLD.
REQ-033 rst asserted in any state, mid-SETTLE included, SHALL abort the in-flight capture and take precedence over all events that cycle.

Verification (SETTLE_CYCLES=2, DWELL_CYCLES=8)
REQ-034 Reset release, page=0, dbg_data=0x12345678 -> busy high 3 cycles; disp_addr=0x00, disp_data=0x12345678; busy low.
REQ-035 page=1 in HOLD with idx=5, then btn_next pulse after capture -> dbg_addr=0x20 next edge, disp_addr=0x20; after pulse, dbg_addr=0x21 and disp_addr=0x21 exactly 3 edges later.
REQ-036 idx=0, btn_prev -> dbg_addr=0x1F (page 0); idx=31, btn_next -> 0x00; btn_next+btn_prev same cycle -> no change, busy stays 0.
REQ-037 auto_en=1 in HOLD, no buttons -> a step every 8 HOLD cycles plus 3 busy cycles; auto_en drop at dwell count 5 -> no step, count restarts at 0.
REQ-038 btn_next pulse during SETTLE -> ignored, idx advances only once; rst during SETTLE -> all outputs 0 next edge.
REQ-039 live_en=1 in HOLD, dbg_data 0xA -> 0xB -> disp_data follows one cycle later; live_en=0 -> disp_data frozen.

Source files
------------

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
// Steps a debug-register index (by buttons, page changes or a dwell timer),
// drives the index onto the datapath debug select, waits for the selected
// data to settle, then commits address/data to the display block.
// In HOLD it can optionally track the selected data every cycle.

module disp_scan_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4,        // 1..255
   parameter int unsigned DWELL_CYCLES  = 50000000  // >= 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_next,
   input  logic        btn_prev,
   input  logic [1:0]  page,
   input  logic        auto_en,
   input  logic        live_en,
   input  logic [31:0] dbg_data,
   output logic [7:0]  dbg_addr,
   output logic [7:0]  disp_addr,
   output logic [31:0] disp_data,
   output logic        busy
);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_SETTLE  = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;

   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);

   logic [1:0]  r_state;
   logic [4:0]  r_idx;
   logic [1:0]  r_page;
   logic [7:0]  r_settle_cnt;
   logic [31:0] r_dwell_cnt;
   logic [7:0]  r_dbg_addr;
   logic [7:0]  r_disp_addr;
   logic [31:0] r_disp_data;

   logic [1:0]  w_eff_page;
   logic        w_page_chg;
   logic        w_auto_tick;
   logic        w_accept;
   logic [1:0]  w_new_page;
   logic [4:0]  w_new_idx;

   // Page 3 has no backing source and aliases the register file.
   assign w_eff_page  = (page == 2'd3) ? 2'd0 : page;
   assign w_page_chg  = (w_eff_page != r_page);
   assign w_auto_tick = auto_en && (r_dwell_cnt == DWELL_LAST);

   // Pick the single highest-priority HOLD event: page change, then a lone
   // button, then the dwell tick. Both buttons together count as no button.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_accept   = 1'b0;
      w_new_page = r_page;
      w_new_idx  = r_idx;
      if (w_page_chg) begin
         w_accept   = 1'b1;
         w_new_page = w_eff_page;
         w_new_idx  = 5'd0;
      end else if (btn_next && !btn_prev) begin
         w_accept  = 1'b1;
         w_new_idx = r_idx + 5'd1;
      end else if (btn_prev && !btn_next) begin
         w_accept  = 1'b1;
         w_new_idx = r_idx - 5'd1;
      end else if (w_auto_tick) begin
         w_accept  = 1'b1;
         w_new_idx = r_idx + 5'd1;
      end
   end

   // Scan state machine: HOLD samples events, SETTLE waits for the datapath,
   // CAPTURE commits. Reset lands in SETTLE so address 0 is captured first.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every read sees the
      // pre-edge value regardless of statement order.
      if (rst) begin
         r_state      <= S_SETTLE;
         r_idx        <= 5'd0;
         r_page       <= 2'd0;
         r_settle_cnt <= 8'd0;
         r_dwell_cnt  <= 32'd0;
         r_dbg_addr   <= 8'h00;
         r_disp_addr  <= 8'h00;
         r_disp_data  <= 32'd0;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (w_accept) begin
                  r_page       <= w_new_page;
                  r_idx        <= w_new_idx;
                  r_dbg_addr   <= {1'b0, w_new_page, w_new_idx};
                  r_dwell_cnt  <= 32'd0;
                  r_settle_cnt <= 8'd0;
                  r_state      <= S_SETTLE;
               end else begin
                  r_dwell_cnt <= auto_en ? (r_dwell_cnt + 32'd1) : 32'd0;
                  if (live_en) begin
                     r_disp_data <= dbg_data;
                  end
               end
            end
            S_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_settle_cnt <= 8'd0;
                  r_state      <= S_CAPTURE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 8'd1;
               end
            end
            S_CAPTURE: begin
               r_disp_addr <= r_dbg_addr;
               r_disp_data <= dbg_data;
               r_state     <= S_HOLD;
            end
            default: begin
               r_state <= S_HOLD;
            end
         endcase
      end
   end

   assign dbg_addr  = r_dbg_addr;
   assign disp_addr = r_disp_addr;
   assign disp_data = r_disp_data;
   assign busy      = (r_state != S_HOLD);

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
// Directed bench for disp_scan_ctrl with SETTLE_CYCLES=2, DWELL_CYCLES=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.

module tb_disp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_next;
   logic        btn_prev;
   logic [1:0]  page;
   logic        auto_en;
   logic        live_en;
   logic [31:0] dbg_data;
   logic [7:0]  dbg_addr;
   logic [7:0]  disp_addr;
   logic [31:0] disp_data;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   disp_scan_ctrl #(
      .SETTLE_CYCLES(2),
      .DWELL_CYCLES (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_next (btn_next),
      .btn_prev (btn_prev),
      .page     (page),
      .auto_en  (auto_en),
      .live_en  (live_en),
      .dbg_data (dbg_data),
      .dbg_addr (dbg_addr),
      .disp_addr(disp_addr),
      .disp_data(disp_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle button pulse sampled at the next edge.
   task automatic step(input logic nx, input logic pv);
      btn_next = nx;
      btn_prev = pv;
      tick();
      btn_next = 1'b0;
      btn_prev = 1'b0;
   endtask

   // Bounded wait for HOLD; an expired budget is a failed comparison.
   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 16) begin
         tick();
         n++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         $display("FAIL %s: busy=%b after %0d cycles, required 0", tag, busy, n);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      page     = 2'd0;
      auto_en  = 1'b0;
      live_en  = 1'b0;
      dbg_data = 32'h12345678;
      tick();
      tick();
      n_checks++; if (busy !== 1'b1) begin $display("FAIL rst_busy: got %b required 1", busy); n_fail++; end
      n_checks++; if (dbg_addr !== 8'h00) begin $display("FAIL rst_dbg_addr: got %h required 00", dbg_addr); n_fail++; end
      n_checks++; if (disp_addr !== 8'h00) begin $display("FAIL rst_disp_addr: got %h required 00", disp_addr); n_fail++; end
      n_checks++; if (disp_data !== 32'h0) begin $display("FAIL rst_disp_data: got %h required 0", disp_data); n_fail++; end
      rst = 1'b0;
      tick();
      n_checks++; if (busy !== 1'b1) begin $display("FAIL rel_busy_2: got %b required 1", busy); n_fail++; end
      tick();
      n_checks++; if (busy !== 1'b1) begin $display("FAIL rel_busy_3: got %b required 1", busy); n_fail++; end
      tick();
      n_checks++; if (busy !== 1'b0) begin $display("FAIL rel_busy_end: got %b required 0", busy); n_fail++; end
      n_checks++; if (disp_addr !== 8'h00) begin $display("FAIL rel_disp_addr: got %h required 00", disp_addr); n_fail++; end
      n_checks++; if (disp_data !== 32'h12345678) begin $display("FAIL rel_disp_data: got %h required 12345678", disp_data); n_fail++; end
   endtask

   task automatic test_page_btn();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0);
         wait_idle("idx_setup");
      end
      n_checks++; if (disp_addr !== 8'h05) begin $display("FAIL idx5_disp_addr: got %h required 05", disp_addr); n_fail++; end
      page = 2'd1;
      tick();
      n_checks++; if (dbg_addr !== 8'h20) begin $display("FAIL page1_dbg_addr: got %h required 20", dbg_addr); n_fail++; end
      n_checks++; if (busy !== 1'b1) begin $display("FAIL page1_busy: got %b required 1", busy); n_fail++; end
      tick();
      tick();
      n_checks++; if (disp_addr !== 8'h05) begin $display("FAIL page1_early: got %h required 05", disp_addr); n_fail++; end
      tick();
      n_checks++; if (disp_addr !== 8'h20) begin $display("FAIL page1_disp_addr: got %h required 20", disp_addr); n_fail++; end
      step(1'b1, 1'b0);
      n_checks++; if (dbg_addr !== 8'h21) begin $display("FAIL next_dbg_addr: got %h required 21", dbg_addr); n_fail++; end
      tick();
      tick();
      n_checks++; if (disp_addr !== 8'h20) begin $display("FAIL next_early: got %h required 20", disp_addr); n_fail++; end
      tick();
      n_checks++; if (disp_addr !== 8'h21) begin $display("FAIL next_disp_addr: got %h required 21", disp_addr); n_fail++; end
      page = 2'd3;
      tick();
      n_checks++; if (dbg_addr !== 8'h00) begin $display("FAIL page3_dbg_addr: got %h required 00", dbg_addr); n_fail++; end
      wait_idle("page3");
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1);
      n_checks++; if (dbg_addr !== 8'h1F) begin $display("FAIL prev_wrap_dbg: got %h required 1f", dbg_addr); n_fail++; end
      wait_idle("prev_wrap");
      n_checks++; if (disp_addr !== 8'h1F) begin $display("FAIL prev_wrap_disp: got %h required 1f", disp_addr); n_fail++; end
      step(1'b1, 1'b0);
      n_checks++; if (dbg_addr !== 8'h00) begin $display("FAIL next_wrap_dbg: got %h required 00", dbg_addr); n_fail++; end
      wait_idle("next_wrap");
      step(1'b1, 1'b1);
      n_checks++; if (busy !== 1'b0) begin $display("FAIL cancel_busy: got %b required 0", busy); n_fail++; end
      n_checks++; if (dbg_addr !== 8'h00) begin $display("FAIL cancel_dbg: got %h required 00", dbg_addr); n_fail++; end
      tick();
      n_checks++; if (busy !== 1'b0) begin $display("FAIL cancel_busy2: got %b required 0", busy); n_fail++; end
   endtask

   task automatic test_auto();
      auto_en = 1'b1;
      repeat (7) tick();
      n_checks++; if (dbg_addr !== 8'h00 || busy !== 1'b0) begin $display("FAIL auto_early1: got %h/%b required 00/0", dbg_addr, busy); n_fail++; end
      tick();
      n_checks++; if (dbg_addr !== 8'h01 || busy !== 1'b1) begin $display("FAIL auto_step1: got %h/%b required 01/1", dbg_addr, busy); n_fail++; end
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin $display("FAIL auto_busy_end: got %b required 0", busy); n_fail++; end
      repeat (7) tick();
      n_checks++; if (dbg_addr !== 8'h01) begin $display("FAIL auto_early2: got %h required 01", dbg_addr); n_fail++; end
      tick();
      n_checks++; if (dbg_addr !== 8'h02) begin $display("FAIL auto_step2: got %h required 02", dbg_addr); n_fail++; end
      repeat (3) tick();
      repeat (5) tick();
      auto_en = 1'b0;
      tick();
      auto_en = 1'b1;
      repeat (7) tick();
      n_checks++; if (dbg_addr !== 8'h02 || busy !== 1'b0) begin $display("FAIL auto_restart: got %h/%b required 02/0", dbg_addr, busy); n_fail++; end
      tick();
      n_checks++; if (dbg_addr !== 8'h03) begin $display("FAIL auto_step3: got %h required 03", dbg_addr); n_fail++; end
      auto_en = 1'b0;
      wait_idle("auto_end");
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b0);
      n_checks++; if (dbg_addr !== 8'h04) begin $display("FAIL b2b_first: got %h required 04", dbg_addr); n_fail++; end
      step(1'b1, 1'b0);
      wait_idle("b2b");
      n_checks++; if (dbg_addr !== 8'h04) begin $display("FAIL b2b_dbg: got %h required 04", dbg_addr); n_fail++; end
      n_checks++; if (disp_addr !== 8'h04) begin $display("FAIL b2b_disp: got %h required 04", disp_addr); n_fail++; end
      tick();
      n_checks++; if (busy !== 1'b0) begin $display("FAIL b2b_queued: got %b required 0", busy); n_fail++; end
      step(1'b1, 1'b0);
      n_checks++; if (dbg_addr !== 8'h05) begin $display("FAIL mid_rst_pre: got %h required 05", dbg_addr); n_fail++; end
      rst      = 1'b1;
      btn_next = 1'b1;
      tick();
      rst      = 1'b0;
      btn_next = 1'b0;
      n_checks++; if (dbg_addr !== 8'h00) begin $display("FAIL mid_rst_dbg: got %h required 00", dbg_addr); n_fail++; end
      n_checks++; if (disp_addr !== 8'h00) begin $display("FAIL mid_rst_disp_addr: got %h required 00", disp_addr); n_fail++; end
      n_checks++; if (disp_data !== 32'h0) begin $display("FAIL mid_rst_disp_data: got %h required 0", disp_data); n_fail++; end
      n_checks++; if (busy !== 1'b1) begin $display("FAIL mid_rst_busy: got %b required 1", busy); n_fail++; end
      wait_idle("post_rst");
      n_checks++; if (disp_data !== 32'h12345678) begin $display("FAIL post_rst_data: got %h required 12345678", disp_data); n_fail++; end
   endtask

   task automatic test_live();
      dbg_data = 32'hA;
      live_en  = 1'b1;
      tick();
      n_checks++; if (disp_data !== 32'hA) begin $display("FAIL live_a: got %h required a", disp_data); n_fail++; end
      dbg_data = 32'hB;
      n_checks++; if (disp_data !== 32'hA) begin $display("FAIL live_lag: got %h required a", disp_data); n_fail++; end
      tick();
      n_checks++; if (disp_data !== 32'hB) begin $display("FAIL live_b: got %h required b", disp_data); n_fail++; end
      n_checks++; if (disp_addr !== 8'h00) begin $display("FAIL live_addr: got %h required 00", disp_addr); n_fail++; end
      live_en  = 1'b0;
      dbg_data = 32'hC;
      tick();
      tick();
      n_checks++; if (disp_data !== 32'hB) begin $display("FAIL live_frozen: got %h required b", disp_data); n_fail++; end
   endtask

   initial begin
      test_reset();
      test_page_btn();
      test_wrap();
      test_auto();
      test_back_to_back();
      test_live();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within 200000 ns");
      $fatal(1, "watchdog");
   end

endmodule
